// File: rtl/apb5_completer_regfile.sv
// APB5 completer in front of a byte-strobed register file with WAIT_STATES wait cycles.
// Define APB5_COMPLETER_PROT_CHECK_EN to reject unprivileged accesses to the upper half of the file.
module apb5_completer_regfile #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 16,
  parameter int WAIT_STATES     = 0,
  parameter int USER_DATA_WIDTH = DATA_WIDTH/2
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [ADDR_WIDTH-1:0]      paddr,
  input  logic [2:0]                 pprot,
  input  logic                       pselx,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_WIDTH-1:0]      pwdata,
  input  logic [DATA_WIDTH/8-1:0]    pstrb,
  input  logic [USER_DATA_WIDTH-1:0] pwuser,
  output logic                       pready,
  output logic [DATA_WIDTH-1:0]      prdata,
  output logic                       pslverr,
  output logic [USER_DATA_WIDTH-1:0] pruser,
  output logic [USER_DATA_WIDTH-1:0] pbuser
);

  localparam int NB    = DATA_WIDTH/8;
  localparam int BW    = $clog2(NB);
  localparam int IW    = $clog2(NUM_REGS);
  localparam int SPAN  = BW + IW;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB-1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q,   cnt_d;
  logic [IW-1:0]              idx_q,   idx_d;
  logic                       err_q,   err_d;
  logic                       write_q, write_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [NB-1:0]              strb_q,  strb_d;
  logic [USER_DATA_WIDTH-1:0] wuser_q, wuser_d;
  logic [2:0]                 prot_q,  prot_d;
  logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]      regs_d [NUM_REGS];

  logic decode_err;
  logic xfer_err;
  logic ready;
  logic commit;
  logic unused_prot;

  // Anything above the file span, or any sub-word offset, is a decode error.
  assign decode_err = (|(paddr >> SPAN)) || (|(paddr & ALIGN_MASK));

`ifdef APB5_COMPLETER_PROT_CHECK_EN
  // The upper half of the file (idx MSB set) is reserved for privileged accesses.
  assign xfer_err    = err_q || (!prot_q[0] && idx_q[IW-1]);
  assign unused_prot = ^prot_q[2:1];
`else
  assign xfer_err    = err_q;
  assign unused_prot = ^prot_q;
`endif

  assign ready  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign commit = ready && pselx && penable && write_q && !xfer_err;

  always_comb begin
    // NOTE: every _d starts from its hold value so no path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    wuser_d = wuser_q;
    prot_d  = prot_q;
    case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = paddr[BW +: IW];
          err_d   = decode_err;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          wuser_d = pwuser;
          prot_d  = pprot;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (ready && penable) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      for (int k = 0; k < NB; k++) begin
        if (strb_q[k]) regs_d[idx_q][8*k +: 8] = wdata_q[8*k +: 8];
      end
    end
  end

  // Response is driven only in the ready cycle and is zero at all other times.
  always_comb begin
    pready  = ready;
    prdata  = '0;
    pslverr = 1'b0;
    pruser  = '0;
    pbuser  = '0;
    if (ready) begin
      pslverr = xfer_err;
      if (write_q) begin
        pbuser = wuser_q;
      end else if (!xfer_err) begin
        prdata = regs_q[idx_q];
        pruser = regs_q[idx_q][USER_DATA_WIDTH-1:0];
      end
    end
  end

  // NOTE: the register file is reset along with the control flops because reads after reset must return 0.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      wuser_q <= '0;
      prot_q  <= '0;
      regs_q  <= '{default: '0};
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      wuser_q <= wuser_d;
      prot_q  <= prot_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: doc/apb5_completer_regfile.md
Name: apb5_completer_regfile

Overview:
- Synthesizable APB5 completer that ends the requester side of the team's APB5 bus: decodes transfers, returns PREADY/PRDATA/PSLVERR and user sidebands.
- Backed by a byte-strobed register file with a programmable number of wait states.
- Used as the reference completer behind the APB5 VIP requester agent and as the CSR block template for subsystems.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values are 8, 16 or 32.
- NUM_REGS, 16, number of DATA_WIDTH registers; a power of two, at least 2.
- WAIT_STATES, 0, extra ACCESS cycles with PREADY low before completion; legal range 0..15.
- USER_DATA_WIDTH, DATA_WIDTH/2, PWUSER/PRUSER/PBUSER width.

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous reset, active-high
- paddr  in  ADDR_WIDTH  byte address
- pprot  in  3  protection attributes
- pselx  in  1  completer select
- penable  in  1  access phase
- pwrite  in  1  1 = write, 0 = read
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write byte strobes
- pwuser  in  USER_DATA_WIDTH  write user data
- pready  out  1  transfer complete
- prdata  out  DATA_WIDTH  read data
- pslverr  out  1  transfer error
- pruser  out  USER_DATA_WIDTH  read user data
- pbuser  out  USER_DATA_WIDTH  write response user data

Behaviour:
- Interface decision: one clock, pclk. Reset is preset, asynchronous and active-high.
- Reset values: all outputs 0, all registers 0, FSM in IDLE, wait counter 0.
- Definitions: B = DATA_WIDTH/8. idx = paddr[log2(B) +: log2(NUM_REGS)].
- Decode error (err) is set when paddr >= NUM_REGS*B, or when paddr[log2(B)-1:0] != 0 (misaligned, for B > 1).
- paddr, pwrite, pwdata, pstrb, pwuser, pprot and err are captured on the setup edge.
- FSM states are IDLE and ACCESS.
- IDLE: pselx=1 and penable=0 at a clock edge -> capture the fields above, load cnt=WAIT_STATES, go to ACCESS. Any other input combination stays in IDLE.
- ACCESS: pready = (cnt==0), combinational from registered state.
  - With WAIT_STATES=0, pready is high in the first access cycle.
  - If cnt != 0 and pselx=1, decrement cnt each edge.
- Completion edge (ACCESS, pselx=1, penable=1, pready=1) -> return to IDLE.
  - A setup phase in the cycle after completion is accepted normally, so back-to-back transfers incur no dead cycles.
- Abort: pselx=0 while in ACCESS (protocol violation) -> go to IDLE with no register update. pready is not asserted.
- Write commit: on the completion edge, if !err, reg[idx] byte k <= pwdata byte k for each k with pstrb[k]=1.
  - pstrb = 0 completes with OKAY and does not modify the register.
- Read data: prdata = reg[idx] only while pready=1, pwrite=0 and !err; otherwise 0. pstrb is ignored on reads.
- pslverr = err, only while pready=1; otherwise 0.
  - An erroring transfer leaves the registers unchanged and drives prdata to 0.
- pruser = reg[idx][USER_DATA_WIDTH-1:0] on an OKAY read completion; otherwise 0.
- pbuser = captured pwuser on a write completion; otherwise 0.
- If the setup signals change during ACCESS, they are ignored; the captured values are used.
- Reset asserted mid-transfer -> immediate return to IDLE and all registers cleared. The transfer has no effect.
- The pwakeup and pauser ports are not implemented by this block; the integrator ties them off at the subsystem level.

Optional Feature:
- Macro: APB5_COMPLETER_PROT_CHECK_EN.
- Defined: a transfer with captured pprot[0]=0 (unprivileged) to idx >= NUM_REGS/2 is an error. It follows the same rules as a decode error: pslverr=1, no write, prdata=0.
- Undefined: pprot is captured but has no effect on behaviour.

Test Plan:
- Defaults, write paddr=0x8, pwdata=0xDEADBEEF, pstrb=0xF, then read 0x8 -> each completes in its first access cycle; read prdata=0xDEADBEEF, pslverr=0, pruser=0xBEEF.
- WAIT_STATES=3, read 0x4 -> pready low for 3 access cycles and high on the 4th; prdata=0 after reset.
- Register 0x0 holds 0x11223344; write pwdata=0xAABBCCDD with pstrb=0b0101 -> read back 0x11BB33DD.
- Access paddr=0x40 (out of range) and paddr=0x6 (misaligned) -> pslverr=1, prdata=0, register contents unchanged.
- Issue back-to-back write then read with no idle cycle between them, then assert preset during a WAIT_STATES=2 write -> the first pair is correct; after the reset the target register reads 0 and the FSM is in IDLE.
- With APB5_COMPLETER_PROT_CHECK_EN defined, write paddr=0x20 with pprot=3'b000 -> pslverr=1 and no update. The same write with pprot=3'b001 -> OKAY and the register is updated.
